// File: rtl/mem_wb_stage_if.sv
// EX/MEM-to-MEM/WB bundle: the EX/MEM register outputs and pipeline controls going in,
// and the MEM/WB register contents coming out.
interface mem_wb_stage_if;
  logic        Valid_in;
  logic [31:0] ALU_Result_in;
  logic [31:0] ReadData2_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        MemToReg_in;
  logic        RegDest_in;
  logic        RegWrite_in;
  logic [14:0] rs_rt_rd_in;
  logic        stall;
  logic        flush;

  logic        Valid_out;
  logic [31:0] WB_Data_out;
  logic [31:0] ALU_Result_out;
  logic [31:0] MemData_out;
  logic [4:0]  WriteReg_out;
  logic        RegWrite_out;
  logic        MemErr_out;

  // Handshake: there is no valid/ready backpressure on this stage. A slot is accepted on every
  // rising edge unless stall is high, Valid_in=0 marks a bubble, and flush overrides stall.
  modport master (
    output Valid_in, ALU_Result_in, ReadData2_in, MemRead_in, MemWrite_in, MemToReg_in,
           RegDest_in, RegWrite_in, rs_rt_rd_in, stall, flush,
    input  Valid_out, WB_Data_out, ALU_Result_out, MemData_out, WriteReg_out,
           RegWrite_out, MemErr_out
  );

  modport slave (
    input  Valid_in, ALU_Result_in, ReadData2_in, MemRead_in, MemWrite_in, MemToReg_in,
           RegDest_in, RegWrite_in, rs_rt_rd_in, stall, flush,
    output Valid_out, WB_Data_out, ALU_Result_out, MemData_out, WriteReg_out,
           RegWrite_out, MemErr_out
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage with word-addressed data memory, followed by the MEM/WB register.
// Loads read the pre-edge memory contents; stores commit on the edge.
module mem_wb_stage #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input logic          clk,
  input logic          reset,
  mem_wb_stage_if.slave bus
);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              out_of_range;
  logic              err;
  logic              store_en;
  logic [31:0]       load_data;

  logic        valid_q,     valid_d;
  logic [31:0] wb_data_q,   wb_data_d;
  logic [31:0] alu_q,       alu_d;
  logic [31:0] mem_data_q,  mem_data_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_err_q,   mem_err_d;

  // rs is carried in the bundle but has no consumer at this stage.
  logic unused_rs;
  assign unused_rs = ^bus.rs_rt_rd_in[14:10];

  always_comb begin
    idx          = bus.ALU_Result_in[ADDR_W+1:2];
    misaligned   = bus.ALU_Result_in[1:0] != 2'b00;
    out_of_range = |bus.ALU_Result_in[31:ADDR_W+2];
    err          = bus.Valid_in & (bus.MemRead_in | bus.MemWrite_in) & (misaligned | out_of_range);
    store_en     = bus.Valid_in & bus.MemWrite_in & ~err & ~bus.stall & ~bus.flush;
    load_data    = (bus.MemRead_in && !err) ? mem_q[idx] : 32'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (store_en) begin
      mem_q[idx] <= bus.ReadData2_in;
    end
  end

  // Priority: flush beats stall; an idle (Valid_in=0) slot enters as a bubble.
  always_comb begin
    valid_d     = valid_q;
    wb_data_d   = wb_data_q;
    alu_d       = alu_q;
    mem_data_d  = mem_data_q;
    write_reg_d = write_reg_q;
    reg_write_d = reg_write_q;
    mem_err_d   = mem_err_q;
    if (bus.flush || (!bus.stall && !bus.Valid_in)) begin
      valid_d     = 1'b0;
      wb_data_d   = 32'd0;
      alu_d       = 32'd0;
      mem_data_d  = 32'd0;
      write_reg_d = 5'd0;
      reg_write_d = 1'b0;
      mem_err_d   = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = 1'b1;
      alu_d       = bus.ALU_Result_in;
      mem_data_d  = load_data;
      wb_data_d   = bus.MemToReg_in ? load_data : bus.ALU_Result_in;
      write_reg_d = bus.RegDest_in ? bus.rs_rt_rd_in[4:0] : bus.rs_rt_rd_in[9:5];
      reg_write_d = bus.RegWrite_in & ~err;
      mem_err_d   = err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      wb_data_q   <= 32'd0;
      alu_q       <= 32'd0;
      mem_data_q  <= 32'd0;
      write_reg_q <= 5'd0;
      reg_write_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      wb_data_q   <= wb_data_d;
      alu_q       <= alu_d;
      mem_data_q  <= mem_data_d;
      write_reg_q <= write_reg_d;
      reg_write_q <= reg_write_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign bus.Valid_out      = valid_q;
  assign bus.WB_Data_out    = wb_data_q;
  assign bus.ALU_Result_out = alu_q;
  assign bus.MemData_out    = mem_data_q;
  assign bus.WriteReg_out   = write_reg_q;
  assign bus.RegWrite_out   = reg_write_q;
  assign bus.MemErr_out     = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized checks of mem_wb_stage against a byte-address/word-array reference.
module tb_mem_wb_stage;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];
  logic        e_valid;
  logic [31:0] e_wb, e_alu, e_md;
  logic [4:0]  e_wr;
  logic        e_rw, e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},     {31'd0, bus.Valid_out},    {31'd0, e_valid});
    check({tag, ".wb_data"},   bus.WB_Data_out,           e_wb);
    check({tag, ".alu"},       bus.ALU_Result_out,        e_alu);
    check({tag, ".mem_data"},  bus.MemData_out,           e_md);
    check({tag, ".write_reg"}, {27'd0, bus.WriteReg_out}, {27'd0, e_wr});
    check({tag, ".reg_write"}, {31'd0, bus.RegWrite_out}, {31'd0, e_rw});
    check({tag, ".mem_err"},   {31'd0, bus.MemErr_out},   {31'd0, e_err});
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    e_valid = 0; e_wb = 0; e_alu = 0; e_md = 0; e_wr = 0; e_rw = 0; e_err = 0;
  endtask

  // Reference: byte address -> word number by division; fault if not a multiple of 4 or past the array.
  task automatic model_edge();
    logic [31:0] a;
    logic        fault;
    logic [31:0] ld;
    longint      word;
    a     = bus.ALU_Result_in;
    word  = longint'(a) / 4;
    fault = bus.Valid_in && (bus.MemRead_in || bus.MemWrite_in) && ((a % 4) != 0 || word >= DEPTH);
    ld    = (bus.MemRead_in && !fault && word < DEPTH) ? ref_mem[int'(word)] : 32'd0;
    if (bus.flush || (!bus.stall && !bus.Valid_in)) begin
      e_valid = 0; e_wb = 0; e_alu = 0; e_md = 0; e_wr = 0; e_rw = 0; e_err = 0;
    end else if (!bus.stall) begin
      e_valid = 1;
      e_alu   = a;
      e_md    = ld;
      e_wb    = bus.MemToReg_in ? ld : a;
      e_wr    = bus.RegDest_in ? bus.rs_rt_rd_in[4:0] : bus.rs_rt_rd_in[9:5];
      e_rw    = bus.RegWrite_in && !fault;
      e_err   = fault;
    end
    if (bus.Valid_in && bus.MemWrite_in && !fault && !bus.stall && !bus.flush)
      ref_mem[int'(word)] = bus.ReadData2_in;
  endtask

  task automatic set_op(input logic v, input logic [31:0] alu, input logic [31:0] d2,
                        input logic mr, input logic mw, input logic m2r, input logic rd,
                        input logic rw, input logic [14:0] regs);
    bus.Valid_in = v; bus.ALU_Result_in = alu; bus.ReadData2_in = d2;
    bus.MemRead_in = mr; bus.MemWrite_in = mw; bus.MemToReg_in = m2r;
    bus.RegDest_in = rd; bus.RegWrite_in = rw; bus.rs_rt_rd_in = regs;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [14:0] r1, r2;
    r1 = 15'b101101000110110;
    r2 = 15'b000100001111001;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.stall = 0; bus.flush = 0;
    model_reset();
    #1;
    check_all("reset");
    #1 reset = 1'b1;

    set_op(1, 8, 13, 0, 1, 0, 1, 0, r1);
    cycle("store8");
    check("store8.wr22", {27'd0, bus.WriteReg_out}, 32'd22);
    set_op(1, 8, 0, 1, 0, 1, 0, 1, r1);
    cycle("load8");
    check("load8.data13", bus.WB_Data_out, 32'd13);
    set_op(1, 31, 0, 0, 0, 0, 1, 1, r2);
    cycle("alu_pass");
    check("alu_pass.wr25", {27'd0, bus.WriteReg_out}, 32'd25);
    set_op(1, 10, 99, 0, 1, 0, 1, 1, r1);
    cycle("st_misalign");
    set_op(1, 8, 0, 1, 0, 1, 0, 1, r1);
    cycle("load8_again");
    set_op(1, 256, 0, 1, 0, 1, 0, 1, r1);
    cycle("ld_oor");
    check("ld_oor.err", {31'd0, bus.MemErr_out}, 32'd1);

    // Stalled store must not commit: swap in a load of the same word when the stall drops.
    set_op(1, 4, 7, 0, 1, 0, 1, 0, r1);
    bus.stall = 1;
    cycle("stall1");
    cycle("stall2");
    bus.stall = 0;
    set_op(1, 4, 0, 1, 0, 1, 1, 1, r2);
    cycle("ld4_zero");
    set_op(1, 4, 7, 0, 1, 0, 1, 0, r1);
    cycle("st4");
    set_op(1, 4, 0, 1, 1, 1, 1, 1, r2);
    bus.ReadData2_in = 32'h55;
    cycle("ldst4_old");
    check("ldst4_old.data7", bus.MemData_out, 32'd7);
    set_op(1, 4, 0, 1, 0, 1, 1, 1, r2);
    cycle("ld4_new");
    bus.stall = 1; bus.flush = 1;
    cycle("flush_stall");
    bus.stall = 0; bus.flush = 0;

    // Asynchronous reset between edges while a store is presented.
    set_op(1, 12, 5, 0, 1, 0, 1, 1, r1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    reset = 1'b1;
    set_op(1, 12, 0, 1, 0, 1, 1, 1, r2);
    #1;
    cycle("ld12_zero");
    set_op(1, 8, 0, 1, 0, 1, 1, 1, r2);
    cycle("ld8_cleared");

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 11);
      if (sel <= 8)       a = 32'($urandom_range(0, 15)) * 4;
      else if (sel == 9)  a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 10) a = 32'($urandom_range(64, 300)) * 4;
      else                a = $urandom;
      set_op(($urandom_range(0, 7) != 0), a, $urandom, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 15'($urandom));
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
